// File: rtl/int_exec_unit.sv
// int_exec_unit: integer execution unit between issue and writeback.
//   Single-cycle ALU / jump-link ops produce a registered result one cycle
//   after accept. MUL/DIV run in an iterative FSM (one bit per cycle) and
//   hold off issue through busy. Branch compares drive a combinational
//   redirect (b_taken/b_addr) in the accept cycle.
// Ports:
//   clk, rstn            clock, async active-low reset
//   in_valid/in_ready    issue handshake (in_ready = ~busy)
//   flush                kill in-flight multi-cycle op, drop same-cycle issue
//   pc, ope, ds_val, dt_val, dd, imm, opr   issued instruction fields
//   b_taken, b_addr      branch redirect to fetch
//   busy                 multi-cycle op in progress
//   out_valid/out_tag/out_val   registered writeback result
module int_exec_unit #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 14,
    parameter int TAG_W    = 6,
    parameter int LINK_TAG = 31
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [PC_W-1:0]   pc,
    input  logic [5:0]        ope,
    input  logic [DATA_W-1:0] ds_val,
    input  logic [DATA_W-1:0] dt_val,
    input  logic [TAG_W-1:0]  dd,
    input  logic [15:0]       imm,
    input  logic [4:0]        opr,
    output logic              b_taken,
    output logic [PC_W-1:0]   b_addr,
    output logic              busy,
    output logic              out_valid,
    output logic [TAG_W-1:0]  out_tag,
    output logic [DATA_W-1:0] out_val
);
    localparam int SH_W = $clog2(DATA_W);

    localparam logic [5:0] OP_LUI  = 6'b110000, OP_ADD  = 6'b001100, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SUB  = 6'b010100, OP_SLL  = 6'b011100, OP_SLLI = 6'b011000;
    localparam logic [5:0] OP_SRL  = 6'b100100, OP_SRLI = 6'b100000, OP_SRA  = 6'b101100;
    localparam logic [5:0] OP_SRAI = 6'b101000, OP_JAL  = 6'b000110, OP_JALR = 6'b001110;
    localparam logic [5:0] OP_BEQ  = 6'b010010, OP_BLE  = 6'b011010, OP_BEQI = 6'b110010;
    localparam logic [5:0] OP_BNEI = 6'b111010, OP_BLEI = 6'b100010, OP_BGTI = 6'b101010;
    localparam logic [5:0] OP_MUL  = 6'b110100, OP_DIV  = 6'b111100;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [SH_W-1:0]    cnt;
    logic [DATA_W-1:0]  acc;    // MUL: partial product   DIV: remainder
    logic [DATA_W-1:0]  opa;    // MUL: multiplicand      DIV: dividend/quotient shift reg
    logic [DATA_W-1:0]  opb;    // MUL: multiplier        DIV: divisor magnitude
    logic               is_div, neg, dz;
    logic [TAG_W-1:0]   tag_q;

    logic               accept;
    logic [DATA_W-1:0]  ex_imm, ex_opr, op2;
    logic [SH_W-1:0]    shamt;
    logic [PC_W-1:0]    pc_inc;
    logic               sc_vld, is_mc, br_cond;
    logic [TAG_W-1:0]   sc_tag;
    logic [DATA_W-1:0]  sc_val;

    assign busy     = (state != IDLE);
    assign in_ready = ~busy;
    assign accept   = in_valid & in_ready & ~flush;

    assign ex_imm = {{(DATA_W-16){imm[15]}}, imm};
    assign ex_opr = {{(DATA_W-5){opr[4]}}, opr};
    assign op2    = ope[2] ? dt_val : ex_imm;
    assign shamt  = op2[SH_W-1:0];
    assign pc_inc = pc + PC_W'(1);

    assign b_taken = accept & br_cond;
    assign b_addr  = PC_W'(imm);

    always_comb begin
        sc_vld  = 1'b0;
        sc_tag  = dd;
        sc_val  = ds_val;
        is_mc   = 1'b0;
        br_cond = 1'b0;
        case (ope)
            OP_LUI:           begin sc_vld = 1'b1; sc_val[31:16] = imm; end
            OP_ADD, OP_ADDI:  begin sc_vld = 1'b1; sc_val = ds_val + op2; end
            OP_SUB:           begin sc_vld = 1'b1; sc_val = ds_val - op2; end
            OP_SLL, OP_SLLI:  begin sc_vld = 1'b1; sc_val = ds_val << shamt; end
            OP_SRL, OP_SRLI:  begin sc_vld = 1'b1; sc_val = ds_val >> shamt; end
            OP_SRA, OP_SRAI:  begin sc_vld = 1'b1; sc_val = $signed(ds_val) >>> shamt; end
            OP_JAL, OP_JALR:  begin
                sc_vld = 1'b1;
                sc_tag = TAG_W'(LINK_TAG);
                sc_val = DATA_W'(pc_inc);
            end
            OP_BEQ:  br_cond = (ds_val == dt_val);
            OP_BLE:  br_cond = ($signed(ds_val) <= $signed(dt_val));
            OP_BEQI: br_cond = (ds_val == ex_opr);
            OP_BNEI: br_cond = (ds_val != ex_opr);
            OP_BLEI: br_cond = ($signed(ds_val) <= $signed(ex_opr));
            OP_BGTI: br_cond = ($signed(ds_val) >  $signed(ex_opr));
            OP_MUL, OP_DIV: is_mc = 1'b1;
            default: ;
        endcase
    end

    // One iteration of shift-add multiply / restoring divide.
    logic [DATA_W-1:0] mul_acc_nx, div_rem_nx, div_quo_nx, rem_sub, mc_res;
    logic [DATA_W:0]   rem_sh;
    logic              ge;

    assign mul_acc_nx = acc + (opb[0] ? opa : '0);
    assign rem_sh     = {acc, opa[DATA_W-1]};
    assign ge         = (rem_sh >= {1'b0, opb});
    // When ge, the true difference is below the divisor, so the low bits suffice.
    assign rem_sub    = rem_sh[DATA_W-1:0] - opb;
    assign div_rem_nx = ge ? rem_sub : rem_sh[DATA_W-1:0];
    assign div_quo_nx = {opa[DATA_W-2:0], ge};
    // MIN / -1 needs no special case: |MIN| / 1 = MIN with positive sign.
    assign mc_res     = !is_div ? mul_acc_nx :
                        dz      ? '1 :
                        neg     ? -div_quo_nx : div_quo_nx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            opa       <= '0;
            opb       <= '0;
            is_div    <= 1'b0;
            neg       <= 1'b0;
            dz        <= 1'b0;
            tag_q     <= '0;
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_val   <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (is_mc) begin
                        state  <= RUN;
                        cnt    <= SH_W'(DATA_W-1);
                        acc    <= '0;
                        is_div <= (ope == OP_DIV);
                        tag_q  <= dd;
                        if (ope == OP_DIV) begin
                            opa <= ds_val[DATA_W-1] ? -ds_val : ds_val;
                            opb <= dt_val[DATA_W-1] ? -dt_val : dt_val;
                        end else begin
                            opa <= ds_val;
                            opb <= dt_val;
                        end
                        neg <= ds_val[DATA_W-1] ^ dt_val[DATA_W-1];
                        dz  <= (dt_val == '0);
                    end else if (sc_vld) begin
                        out_valid <= 1'b1;
                        out_tag   <= sc_tag;
                        out_val   <= sc_val;
                    end
                end
                RUN: if (flush) begin
                    state <= IDLE;
                end else begin
                    if (is_div) begin
                        acc <= div_rem_nx;
                        opa <= div_quo_nx;
                    end else begin
                        acc <= mul_acc_nx;
                        opa <= opa << 1;
                        opb <= opb >> 1;
                    end
                    cnt <= cnt - SH_W'(1);
                    if (cnt == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_tag   <= tag_q;
                        out_val   <= mc_res;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
